// File: rtl/keccak_pkg.sv
// Shared constants, state encoding and rate helper for the keccak padder.
package keccak_pkg;

    localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
    localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int rate_bytes(input int d, input int l);
        return (25 * (2 ** l) - 2 * d) / 8;
    endfunction

endpackage

// File: rtl/dffre.sv
// Register with asynchronous active-high reset to zero and load enable.
module dffre #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/keccak_pad_insert.sv
// Byte-lane write mask and data/pad overlay for one word landing at ptr.
module keccak_pad_insert #(
    parameter int R        = 172,
    parameter int IN_BYTES = 4,
    parameter int PW       = $clog2(R + 1),
    parameter int NW       = $clog2(IN_BYTES) + 1
) (
    input  logic [PW-1:0]         ptr,
    input  logic [NW-1:0]         n,
    input  logic                  last,
    input  logic [7:0]            suffix,
    input  logic [8*IN_BYTES-1:0] data,
    output logic [R-1:0]          we,
    output logic [8*R-1:0]        ovl
);

    localparam int BW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;

    logic [7:0] bytes [IN_BYTES];
    int         p;
    int         e;

    always_comb begin
        for (int j = 0; j < IN_BYTES; j++) bytes[j] = data[8*j +: 8];
    end

    always_comb begin
        we  = '0;
        ovl = '0;
        p   = int'(ptr);
        e   = int'(ptr) + int'(n);
        for (int k = 0; k < R; k++) begin
            if (k >= p && k < e) begin
                we[k]        = 1'b1;
                ovl[8*k +: 8] = bytes[BW'(k - p)];
            end
            // Bytes past the fill point are zero, so OR-ing pad bits is a plain write.
            if (last && e < R) begin
                if (k == e) begin
                    we[k]         = 1'b1;
                    ovl[8*k +: 8] = ovl[8*k +: 8] | suffix;
                end
                if (k == R - 1) begin
                    we[k]         = 1'b1;
                    ovl[8*k +: 8] = ovl[8*k +: 8] | 8'h80;
                end
            end
        end
    end

endmodule

// File: rtl/keccak_padder.sv
// SHA-3/SHAKE pad10*1 block assembler in front of the keccak absorb core.
// Define KECCAK_PADDER_ERR_EN to enable the sticky in_bytes protocol check.
module keccak_padder
    import keccak_pkg::*;
#(
    parameter int         d        = 112,
    parameter int         l        = 6,
    parameter int         w        = 2 ** l,
    parameter int         b        = 25 * w,
    parameter int         c        = 2 * d,
    parameter int         r        = b - c,
    parameter int         R        = r / 8,
    parameter int         IN_BYTES = 4,
    parameter logic [7:0] SUFFIX   = SUFFIX_SHA3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [8*IN_BYTES-1:0]        in_data,
    input  logic [$clog2(IN_BYTES):0]    in_bytes,
    input  logic                         in_last,
    output logic                         block_valid,
    input  logic                         block_ready,
    output logic [r-1:0]                 block,
    output logic                         block_last,
    output logic                         error
);

    localparam int PW = $clog2(R + 1);
    localparam int NW = $clog2(IN_BYTES) + 1;

    state_t          state;
    state_t          state_n;
    logic            state_q;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_n;
    logic            pad_pending;
    logic            pad_n;
    logic            last_n;
    logic [r-1:0]    block_n;
    logic [NW-1:0]   n;
    logic [PW:0]     fill_end;
    logic            accept;
    logic            hshake;
    logic            upd;

    logic [PW-1:0]   pi_ptr;
    logic [NW-1:0]   pi_n;
    logic            pi_last;
    logic [R-1:0]    we;
    logic [8*R-1:0]  ovl;

    assign state       = state_t'(state_q);
    assign in_ready    = (state == FILL);
    assign block_valid = (state == EMIT);
    assign accept      = in_valid && in_ready;
    assign hshake      = block_valid && block_ready;
    assign upd         = accept || hshake;

    always_comb begin
        if (!in_last || in_bytes > NW'(IN_BYTES)) n = NW'(IN_BYTES);
        else n = in_bytes;
    end

    assign fill_end = {1'b0, ptr} + (PW + 1)'(n);

    // In EMIT the inserter is steered to produce the pad-only block.
    assign pi_ptr  = in_ready ? ptr : '0;
    assign pi_n    = in_ready ? n : '0;
    assign pi_last = in_ready ? in_last : 1'b1;

    keccak_pad_insert #(
        .R        (R),
        .IN_BYTES (IN_BYTES),
        .PW       (PW),
        .NW       (NW)
    ) u_ins (
        .ptr    (pi_ptr),
        .n      (pi_n),
        .last   (pi_last),
        .suffix (SUFFIX),
        .data   (in_data),
        .we     (we),
        .ovl    (ovl)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        pad_n   = pad_pending;
        last_n  = block_last;
        block_n = block;
        if (accept) begin
            for (int k = 0; k < R; k++) begin
                if (we[k]) block_n[8*k +: 8] = ovl[8*k +: 8];
            end
            ptr_n = fill_end[PW-1:0];
            if (in_last) begin
                state_n = EMIT;
                if (fill_end == (PW + 1)'(R)) pad_n = 1'b1;
                else last_n = 1'b1;
            end else if (fill_end == (PW + 1)'(R)) begin
                state_n = EMIT;
            end
        end else if (hshake) begin
            if (pad_pending) begin
                block_n = ovl;
                last_n  = 1'b1;
                pad_n   = 1'b0;
            end else begin
                block_n = '0;
                ptr_n   = '0;
                last_n  = 1'b0;
                state_n = FILL;
            end
        end
    end

    dffre #(.W(1)) u_state (
        .clk(clk), .reset(reset), .en(upd), .d(state_n), .q(state_q)
    );

    dffre #(.W(PW)) u_ptr (
        .clk(clk), .reset(reset), .en(upd), .d(ptr_n), .q(ptr)
    );

    dffre #(.W(1)) u_pad (
        .clk(clk), .reset(reset), .en(upd), .d(pad_n), .q(pad_pending)
    );

    dffre #(.W(1)) u_last (
        .clk(clk), .reset(reset), .en(upd), .d(last_n), .q(block_last)
    );

    dffre #(.W(r)) u_block (
        .clk(clk), .reset(reset), .en(upd), .d(block_n), .q(block)
    );

`ifdef KECCAK_PADDER_ERR_EN
    logic err_n;
    logic bad;

    assign bad   = in_last ? (in_bytes > NW'(IN_BYTES))
                           : (in_bytes != NW'(IN_BYTES));
    assign err_n = error || (accept && bad);

    dffre #(.W(1)) u_err (
        .clk(clk), .reset(reset), .en(1'b1), .d(err_n), .q(error)
    );
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_padder.sv
// Directed self-checking bench for keccak_padder with default parameters.
module tb_keccak_padder;
    import keccak_pkg::*;

    localparam int R  = rate_bytes(112, 6);
    localparam int RB = 8 * R;
`ifdef KECCAK_PADDER_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          block_ready = 1'b0;
    logic [31:0]   in_data = '0;
    logic [2:0]    in_bytes = '0;
    logic          in_ready;
    logic          block_valid;
    logic          block_last;
    logic          error;
    logic [RB-1:0] block;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    keccak_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_bytes    (in_bytes),
        .in_last     (in_last),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block       (block),
        .block_last  (block_last),
        .error       (error)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reports the lowest differing byte, or byte 0 when all match.
    task automatic check_blk(input string tag, input logic [RB-1:0] exp);
        int idx = 0;
        for (int k = R - 1; k >= 0; k--)
            if (block[8*k +: 8] !== exp[8*k +: 8]) idx = k;
        check($sformatf("%s[%0d]", tag, idx),
              64'(block[8*idx +: 8]), 64'(exp[8*idx +: 8]));
    endtask

    task automatic send(input logic [31:0] dat, input logic [2:0] nb,
                        input logic last);
        int t = 0;
        in_data  = dat;
        in_bytes = nb;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take(input string tag, input logic [RB-1:0] exp,
                        input logic last);
        int t = 0;
        while (!block_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, 64'(block_valid), 64'd1);
        check_blk({tag, "_blk"}, exp);
        check({tag, "_last"}, 64'(block_last), 64'(last));
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
    endtask

    function automatic logic [RB-1:0] pad_blk();
        logic [RB-1:0] e = '0;
        e[7:0]        = 8'h06;
        e[RB-8 +: 8]  = 8'h80;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [RB-1:0] e;
        logic [RB-1:0] m;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(block_valid), 64'd0);
        check("rst_last", 64'(block_last), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check_blk("rst_blk", '0);

        send(32'h0, 3'd0, 1'b1);
        take("empty", pad_blk(), 1'b1);
        check("empty_ready_after", 64'(in_ready), 64'd1);

        e = pad_blk();
        e[31:0] = 32'h06636261;
        send(32'h00636261, 3'd3, 1'b1);
        take("abc", e, 1'b1);

        m = '0;
        for (int i = 0; i < 171; i++) m[8*i +: 8] = 8'(i);
        for (int wd = 0; wd < 42; wd++) send(m[32*wd +: 32], 3'd4, 1'b0);
        send(m[32*42 +: 32], 3'd3, 1'b1);
        e = m;
        e[RB-8 +: 8] = 8'h86;
        take("m171", e, 1'b1);

        m = '0;
        for (int i = 0; i < 172; i++) m[8*i +: 8] = 8'hFF - 8'(i);
        for (int wd = 0; wd < 42; wd++) send(m[32*wd +: 32], 3'd4, 1'b0);
        send(m[32*42 +: 32], 3'd4, 1'b1);
        take("m172_data", m, 1'b0);
        check("m172_ready_mid", 64'(in_ready), 64'd0);
        take("m172_pad", pad_blk(), 1'b1);

        for (int i = 0; i < 172; i++) m[8*i +: 8] = 8'(i) ^ 8'h5A;
        for (int wd = 0; wd < 43; wd++) send(m[32*wd +: 32], 3'd4, 1'b0);
        in_data  = 32'hAABBCCDD;
        in_bytes = 3'd0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int cy = 0; cy < 5; cy++) begin
            check($sformatf("bp_ready_%0d", cy), 64'(in_ready), 64'd0);
            check($sformatf("bp_valid_%0d", cy), 64'(block_valid), 64'd1);
            check_blk($sformatf("bp_blk_%0d", cy), m);
            @(negedge clk);
        end
        check("bp_last", 64'(block_last), 64'd0);
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        take("bp_pad", pad_blk(), 1'b1);

        send(32'h11223344, 3'd4, 1'b0);
        send(32'h55667788, 3'd4, 1'b0);
        reset = 1'b1;
        #1;
        check_blk("rst_mid_blk", '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        e = pad_blk();
        e[31:0] = 32'h06636261;
        send(32'h00636261, 3'd3, 1'b1);
        take("rst_abc", e, 1'b1);

        send(32'h44434241, 3'd2, 1'b0);
        check("err_set", 64'(error), 64'(EXP_ERR));
        send(32'h0, 3'd0, 1'b1);
        e = pad_blk();
        e[31:0] = 32'h44434241;
        e[39:32] = 8'h06;
        e[7:0] = 8'h41;
        take("err_blk", e, 1'b1);
        check("err_sticky", 64'(error), 64'(EXP_ERR));

        send(32'h48474645, 3'd5, 1'b1);
        e = pad_blk();
        e[39:0] = 40'h0648474645;
        take("over_blk", e, 1'b1);
        check("over_err", 64'(error), 64'(EXP_ERR));

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("err_cleared", 64'(error), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
